// File: rtl/conv1_pkg.sv
// Shared definitions for the conv1 frame sequencer: FSM state encoding and
// the fixed image/result geometry of the first MNIST convolution layer.
package conv1_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      FETCH = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int IMG_PIX = 784;   // 28 x 28 input pixels
   localparam int OUT_PIX = 576;   // 24 x 24 valid conv outputs
   localparam int OUT_W   = 24;    // output side length

endpackage

// File: rtl/conv1_res_wr.sv
// Result writer: counts accepted conv1 outputs, registers the result-memory
// write port and tells the FSM when the last output of the frame is taken.
module conv1_res_wr
   import conv1_pkg::*;
#(
   parameter int CONV_BITS = 12,
   parameter int OUT_N     = OUT_PIX
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   cap_en,
   input  logic                   conv_valid,
   input  logic [CONV_BITS-1:0]   conv_out_1,
   input  logic [CONV_BITS-1:0]   conv_out_2,
   input  logic [CONV_BITS-1:0]   conv_out_3,
   output logic                   full,
   output logic                   last,
   output logic                   res_we,
   output logic [9:0]             res_addr,
   output logic [3*CONV_BITS-1:0] res_data
);

   localparam logic [9:0] OUT_N_C    = 10'(OUT_N);
   localparam logic [9:0] OUT_LAST_C = 10'(OUT_N - 1);

   logic [9:0]             out_cnt_r;
   logic                   res_we_r;
   logic [9:0]             res_addr_r;
   logic [3*CONV_BITS-1:0] res_data_r;
   logic                   cap_s;

   // A valid is only taken inside the capture window and while the count is
   // below the frame total, so out_cnt saturates at OUT_N by construction.
   assign cap_s = cap_en && conv_valid && (out_cnt_r < OUT_N_C);
   assign full  = (out_cnt_r == OUT_N_C);
   assign last  = cap_s && (out_cnt_r == OUT_LAST_C);

   // Output counter and registered result-memory write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_cnt_r  <= 10'd0;
         res_we_r   <= 1'b0;
         res_addr_r <= 10'd0;
         res_data_r <= {(3*CONV_BITS){1'b0}};
      end else begin
         res_we_r <= cap_s;
         if (clr) begin
            out_cnt_r <= 10'd0;
         end else if (cap_s) begin
            out_cnt_r <= out_cnt_r + 10'd1;
         end else begin
            out_cnt_r <= out_cnt_r;
         end
         if (cap_s) begin
            res_addr_r <= out_cnt_r;
            res_data_r <= {conv_out_1, conv_out_2, conv_out_3};
         end else begin
            res_addr_r <= res_addr_r;
            res_data_r <= res_data_r;
         end
      end
   end

   assign res_we   = res_we_r;
   assign res_addr = res_addr_r;
   assign res_data = res_data_r;

endmodule

// File: rtl/conv1_frame_ctrl.sv
// Frame sequencer for conv1: flushes the line buffer, streams one image from
// the image memory into conv1_layer and collects the valid results.
module conv1_frame_ctrl
   import conv1_pkg::*;
#(
   parameter int IMG_W     = 28,
   parameter int IMG_H     = 28,
   parameter int K         = 5,
   parameter int DATA_BITS = 8,
   parameter int CONV_BITS = 12,
   parameter int DRAIN_MAX = 64
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [9:0]             img_addr,
   output logic                   img_rd_en,
   input  logic [DATA_BITS-1:0]   img_rd_data,
   output logic                   conv_rst_n,
   output logic [DATA_BITS-1:0]   conv_data_in,
   input  logic                   conv_valid,
   input  logic [CONV_BITS-1:0]   conv_out_1,
   input  logic [CONV_BITS-1:0]   conv_out_2,
   input  logic [CONV_BITS-1:0]   conv_out_3,
   output logic                   res_we,
   output logic [9:0]             res_addr,
   output logic [3*CONV_BITS-1:0] res_data
);

   localparam int              PIX_N      = IMG_W * IMG_H;
   localparam int              OUT_SIDE   = IMG_W - K + 1;
   localparam int              DW         = $clog2(DRAIN_MAX + 1);
   localparam logic [9:0]      LAST_ADDR  = 10'(PIX_N - 1);
   localparam logic [DW-1:0]   DRAIN_LAST = DW'(DRAIN_MAX - 1);

   state_t               state_r, next_state_s;
   logic [9:0]           pix_cnt_r, pix_nx_s;
   logic [DW-1:0]        drain_cnt_r;
   logic                 rd_d1_r;
   logic                 accept_s, timeout_s, cap_en_s, full_s, last_s;

   logic                 busy_r, done_r, err_r, img_rd_en_r, conv_rst_n_r;
   logic [9:0]           img_addr_r;
   logic [DATA_BITS-1:0] conv_data_in_r;
   logic                 busy_nx_s, done_nx_s, err_nx_s, rd_en_nx_s, crst_nx_s;
   logic [9:0]           addr_nx_s;

   assign accept_s  = (state_r == IDLE) && start;
   // The drain limit is hit on the cycle whose increment reaches DRAIN_MAX.
   assign timeout_s = (state_r == DRAIN) && (drain_cnt_r == DRAIN_LAST);
   assign cap_en_s  = (state_r == CLR) || (state_r == FETCH) || (state_r == DRAIN);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state: a completed output count ends the frame from any active state.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_state_s = CLR;
            else       next_state_s = IDLE;
         end
         CLR: begin
            if (full_s) next_state_s = DONE;
            else        next_state_s = FETCH;
         end
         FETCH: begin
            if (full_s)                        next_state_s = DONE;
            else if (pix_cnt_r == LAST_ADDR)   next_state_s = DRAIN;
            else                               next_state_s = FETCH;
         end
         DRAIN: begin
            if (full_s || timeout_s) next_state_s = DONE;
            else                     next_state_s = DRAIN;
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // FSM outputs, computed from the next state so they can be registered.
   always_comb begin
      if (accept_s)                pix_nx_s = 10'd0;
      else if (state_r == FETCH)   pix_nx_s = pix_cnt_r + 10'd1;
      else                         pix_nx_s = pix_cnt_r;
      busy_nx_s  = (next_state_s != IDLE);
      done_nx_s  = (next_state_s == DONE);
      rd_en_nx_s = (next_state_s == FETCH);
      crst_nx_s  = (next_state_s != CLR);
      if (next_state_s == FETCH) addr_nx_s = pix_nx_s;
      else                       addr_nx_s = 10'd0;
      // A capture landing on the timeout cycle that completes the frame wins.
      if (accept_s)                              err_nx_s = 1'b0;
      else if (timeout_s && !full_s && !last_s)  err_nx_s = 1'b1;
      else                                       err_nx_s = err_r;
   end

   // Pixel counter, drain counter and read-valid delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt_r   <= 10'd0;
         drain_cnt_r <= {DW{1'b0}};
         rd_d1_r     <= 1'b0;
      end else begin
         pix_cnt_r <= pix_nx_s;
         rd_d1_r   <= img_rd_en_r;
         if (accept_s)               drain_cnt_r <= {DW{1'b0}};
         else if (state_r == DRAIN)  drain_cnt_r <= drain_cnt_r + DW'(1);
         else                        drain_cnt_r <= drain_cnt_r;
      end
   end

   // Registered control outputs and the pixel stream into conv1_layer.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         err_r          <= 1'b0;
         img_rd_en_r    <= 1'b0;
         img_addr_r     <= 10'd0;
         conv_rst_n_r   <= 1'b0;
         conv_data_in_r <= {DATA_BITS{1'b0}};
      end else begin
         busy_r         <= busy_nx_s;
         done_r         <= done_nx_s;
         err_r          <= err_nx_s;
         img_rd_en_r    <= rd_en_nx_s;
         img_addr_r     <= addr_nx_s;
         conv_rst_n_r   <= crst_nx_s;
         conv_data_in_r <= rd_d1_r ? img_rd_data : {DATA_BITS{1'b0}};
      end
   end

   conv1_res_wr #(
      .CONV_BITS (CONV_BITS),
      .OUT_N     (OUT_SIDE * OUT_SIDE)
   ) u_res_wr (
      .clk        (clk),
      .rst        (rst),
      .clr        (accept_s),
      .cap_en     (cap_en_s),
      .conv_valid (conv_valid),
      .conv_out_1 (conv_out_1),
      .conv_out_2 (conv_out_2),
      .conv_out_3 (conv_out_3),
      .full       (full_s),
      .last       (last_s),
      .res_we     (res_we),
      .res_addr   (res_addr),
      .res_data   (res_data)
   );

   assign busy         = busy_r;
   assign done         = done_r;
   assign err          = err_r;
   assign img_rd_en    = img_rd_en_r;
   assign img_addr     = img_addr_r;
   assign conv_rst_n   = conv_rst_n_r;
   assign conv_data_in = conv_data_in_r;

endmodule

// File: tb/tb_conv1_frame_ctrl.sv
// Directed bench for conv1_frame_ctrl: ramp image memory, stubbed conv1
// valid stream, and a scoreboard of expected result-memory writes.
module tb_conv1_frame_ctrl;

   localparam int DATA_BITS   = 8;
   localparam int CONV_BITS   = 12;
   localparam int DRAIN_MAX   = 64;
   localparam int FETCH_LAST  = 785;                       // last read cycle after start
   localparam int DRAIN_START = 786;
   localparam int TO_CYC      = DRAIN_START + DRAIN_MAX - 1; // timeout decision cycle
   localparam int DONE_TO     = DRAIN_START + DRAIN_MAX;     // done cycle on timeout

   logic                   clk = 1'b0;
   logic                   rst, start, busy, done, err, img_rd_en, conv_rst_n;
   logic [9:0]             img_addr, res_addr;
   logic [DATA_BITS-1:0]   img_rd_data, conv_data_in;
   logic                   conv_valid, res_we;
   logic [CONV_BITS-1:0]   conv_out_1, conv_out_2, conv_out_3;
   logic [3*CONV_BITS-1:0] res_data;

   typedef struct {
      logic [9:0]             addr;
      logic [3*CONV_BITS-1:0] data;
   } exp_t;

   exp_t q[$];
   exp_t e_m;
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt = 0;

   conv1_frame_ctrl #(
      .IMG_W(28), .IMG_H(28), .K(5), .DATA_BITS(DATA_BITS),
      .CONV_BITS(CONV_BITS), .DRAIN_MAX(DRAIN_MAX)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .img_addr(img_addr), .img_rd_en(img_rd_en), .img_rd_data(img_rd_data),
      .conv_rst_n(conv_rst_n), .conv_data_in(conv_data_in), .conv_valid(conv_valid),
      .conv_out_1(conv_out_1), .conv_out_2(conv_out_2), .conv_out_3(conv_out_3),
      .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
   );

   always #5 clk = ~clk;

   // Ramp image memory with one-cycle read latency; junk when not read.
   always @(posedge clk) img_rd_data <= img_rd_en ? img_addr[7:0] : 8'hA5;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every result write must match the oldest expected capture.
   always @(negedge clk) begin
      if (res_we === 1'b1) begin
         wr_cnt++;
         if (q.size() == 0) begin
            chk("res_we_spurious", 64'(res_we), 64'(0));
         end else begin
            e_m = q.pop_front();
            chk("res_addr", 64'(res_addr), 64'(e_m.addr));
            chk("res_data", 64'(res_data), 64'(e_m.data));
         end
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_busy"},       64'(busy),         64'(0));
      chk({tag, "_done"},       64'(done),         64'(0));
      chk({tag, "_err"},        64'(err),          64'(0));
      chk({tag, "_img_addr"},   64'(img_addr),     64'(0));
      chk({tag, "_img_rd_en"},  64'(img_rd_en),    64'(0));
      chk({tag, "_conv_rst_n"}, 64'(conv_rst_n),   64'(0));
      chk({tag, "_conv_data"},  64'(conv_data_in), 64'(0));
      chk({tag, "_res_we"},     64'(res_we),       64'(0));
      chk({tag, "_res_addr"},   64'(res_addr),     64'(0));
      chk({tag, "_res_data"},   64'(res_data),     64'(0));
   endtask

   // One frame: start is sampled at the end of the calling cycle, c counts
   // cycles after that. The stub drives n_valid consecutive valids from v_first.
   task automatic run_frame(input int n_valid, input int v_first, input bit hold, input int abort_c);
      int cnt, t576, done_exp, exp_cnt, run_cnt, end_c, last_v, k, px;
      bit err_exp, is_v, rd_exp;
      logic [CONV_BITS-1:0] o1, o2, o3;
      exp_t e;
      cnt = 0;
      t576 = -1;
      for (int i = 0; i < n_valid; i++) begin
         if ((v_first + i) <= TO_CYC && (abort_c == 0 || (v_first + i) < abort_c) && cnt < 576) begin
            cnt++;
            if (cnt == 576) t576 = v_first + i;
         end
      end
      if (t576 >= 0) done_exp = (t576 + 2 < DONE_TO) ? t576 + 2 : DONE_TO;
      else           done_exp = DONE_TO;
      err_exp = (t576 < 0);
      exp_cnt = cnt;
      last_v  = v_first + n_valid - 1;
      if (hold)                        end_c = done_exp + 1;
      else if (last_v + 1 > done_exp + 2) end_c = last_v + 1;
      else                             end_c = done_exp + 2;
      if (abort_c != 0) end_c = abort_c;
      wr_cnt  = 0;
      run_cnt = 0;
      start   = 1'b1;
      for (int c = 1; c <= end_c; c++) begin
         @(negedge clk);
         if (!hold) start = 1'b0;
         chk("busy",       64'(busy),       64'(c <= done_exp));
         chk("done",       64'(done),       64'(c == done_exp));
         chk("err",        64'(err),        64'((c >= done_exp) ? err_exp : 1'b0));
         chk("conv_rst_n", 64'(conv_rst_n), 64'(c != 1));
         rd_exp = (c >= 2) && (c <= FETCH_LAST) && (c < done_exp);
         chk("img_rd_en",  64'(img_rd_en),  64'(rd_exp));
         if (rd_exp) chk("img_addr", 64'(img_addr), 64'(c - 2));
         k  = c - 4;
         px = (k >= 0 && k <= 783 && k + 2 < done_exp) ? (k % 256) : 0;
         chk("conv_data_in", 64'(conv_data_in), 64'(px));
         if (c == abort_c) begin
            rst        = 1'b1;
            conv_valid = 1'b0;
         end else begin
            is_v = (c >= v_first) && (c <= last_v);
            o1 = 12'($urandom_range(0, 4095));
            o2 = 12'($urandom_range(0, 4095));
            o3 = 12'($urandom_range(0, 4095));
            conv_valid = is_v;
            conv_out_1 = o1;
            conv_out_2 = o2;
            conv_out_3 = o3;
            if (is_v && run_cnt < 576 && c <= TO_CYC && c < done_exp) begin
               e.addr = 10'(run_cnt);
               e.data = {o1, o2, o3};
               q.push_back(e);
               run_cnt++;
            end
         end
      end
      conv_valid = 1'b0;
      if (abort_c != 0) begin
         @(negedge clk);
         chk_reset_vals("abort");
         rst = 1'b0;
      end
      #1;
      chk("sb_empty", 64'(q.size()), 64'(0));
      chk("wr_count", 64'(wr_cnt),   64'(exp_cnt));
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      conv_valid = 1'b0;
      conv_out_1 = 12'd0;
      conv_out_2 = 12'd0;
      conv_out_3 = 12'd0;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;
      // Idle with no start: nothing may move.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_busy",       64'(busy),       64'(0));
         chk("idle_rd_en",      64'(img_rd_en),  64'(0));
         chk("idle_conv_rst_n", 64'(conv_rst_n), 64'(1));
         chk("idle_res_we",     64'(res_we),     64'(0));
         chk("idle_done",       64'(done),       64'(0));
      end
      // Normal frame, 576th output arrives during DRAIN.
      run_frame(576, 225, 1'b0, 0);
      // Only 575 outputs: drain timeout, err set and sticky.
      run_frame(575, 50, 1'b0, 0);
      // 580 outputs, 576th on the timeout cycle: err cleared by start, stays 0.
      run_frame(580, 274, 1'b0, 0);
      // start held high: one frame, next accepted only after DONE -> IDLE.
      run_frame(576, 10, 1'b1, 0);
      // The second frame from the held start is reset at pixel 400.
      run_frame(576, 5, 1'b0, 402);
      // Clean frame after the reset, res_addr restarts at 0.
      run_frame(576, 230, 1'b0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
